// File: rtl/multi_seq_if.sv
// multi_seq_if: start/busy/done handshake and operand/product bus for multi_seq.
//   master: drives start, a, b; observes busy, done, S
//   slave : the multiplier; observes start, a, b; drives busy, done, S
interface multi_seq_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   S;

    modport master (output start, a, b, input busy, done, S);
    modport slave  (input start, a, b, output busy, done, S);
endinterface

// File: rtl/multi_seq.sv
// multi_seq: sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One LSB-first iteration per clock; the product lands in S on the edge that
// enters DONE, which pulses done for one cycle. S holds between operations.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - multi_seq_if.slave (start, a, b in; busy, done, S out)
// Build option: define MULT_SIGNED_EN for two's-complement operands and product;
// otherwise the block is purely unsigned.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; S holds the last product
// RUN   | WIDTH shift-add steps, busy=1, start ignored
// DONE  | one cycle, done=1, S valid; start here issues back-to-back
module multi_seq #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    multi_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   s_q, s_d;
`ifdef MULT_SIGNED_EN
    logic                 neg_q, neg_d;
`endif

    logic [WIDTH:0]       addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   result;
    logic                 accept;

`ifdef MULT_SIGNED_EN
    // Magnitude of a two's-complement value; the most negative input maps to
    // 2^(WIDTH-1), which is still representable unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(~v + WIDTH'(1)) : v;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        s_d      = s_q;
`ifdef MULT_SIGNED_EN
        neg_d    = neg_q;
`endif

        // Carry out of the upper-half add is kept and shifted back in.
        addend   = mplier_q[0] ? {1'b0, mcand_q} : '0;
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + addend;
        acc_step = (2*WIDTH)'({sum, acc_q[WIDTH-1:0]} >> 1);

`ifdef MULT_SIGNED_EN
        result   = neg_q ? (2*WIDTH)'(~acc_step + (2*WIDTH)'(1)) : acc_step;
`else
        result   = acc_step;
`endif

        accept   = bus.start && (state_q != RUN);

        case (state_q)
            IDLE: begin
            end
            RUN: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    s_d     = result;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            acc_d   = '0;
`ifdef MULT_SIGNED_EN
            mcand_d  = magnitude(bus.a);
            mplier_d = magnitude(bus.b);
            neg_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`else
            mcand_d  = bus.a;
            mplier_d = bus.b;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            s_q      <= '0;
`ifdef MULT_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            s_q      <= s_d;
`ifdef MULT_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.S    = s_q;

endmodule
